// File: rtl/spi_pkg.sv
// Shared definitions for blocks that drive the 24-bit SPI transmitter.
// Holds the word width, the default watchdog limit and the arbiter FSM encoding.
package spi_pkg;

    localparam int SPI_DATA_W             = 24;
    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        LOAD  = 3'd2,
        WAIT  = 3'd3,
        ACK   = 3'd4
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request above ptr, wrapping modulo N.
// any_req is low when no request is set; grant is then 0 and must be ignored.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] grant,
    output logic           any_req
);

    always_comb begin
        int idx;
        idx     = 0;
        grant   = '0;
        any_req = 1'b0;
        // ptr < N and i <= N, so a single subtraction is enough to wrap
        for (int i = 1; i <= N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                grant   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin sharing of one SPI transmitter between NUM_REQ requesters,
// with a resynchronised done_send handshake and a per-phase watchdog.
module spi_tx_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = SPI_DATA_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int IDW           = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [IDW-1:0]            grant_id,
    output logic                      busy,
    output logic [DATA_W-1:0]         spi_data_in,
    output logic                      spi_load_data,
    input  logic                      spi_done_send,
    output logic                      timeout_err,
    output arb_state_e                state_dbg
);

    localparam int WDW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    // Handshake: spi_load_data is held high until done_s falls (word accepted),
    // then the transfer is complete once done_s rises again (transmitter idle).
    arb_state_e     state, state_nxt;
    logic           sync1, done_s;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] pick;
    logic           any_req;
    logic [WDW-1:0] wd_cnt;
    logic           wd_expired;
    logic           abort;

    rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_rr (
        .req     (req),
        .ptr     (ptr),
        .grant   (pick),
        .any_req (any_req)
    );

    assign wd_expired = (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        case (state)
            IDLE:  if (|req && done_s) state_nxt = GRANT;
            GRANT: state_nxt = any_req ? LOAD : IDLE;
            LOAD: begin
                if (!done_s) begin
                    state_nxt = WAIT;
                end else if (wd_expired) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end
            end
            WAIT: begin
                if (done_s) begin
                    state_nxt = ACK;
                end else if (wd_expired) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sync1       <= 1'b0;
            done_s      <= 1'b0;
            ptr         <= '0;
            grant_id    <= '0;
            spi_data_in <= '0;
            timeout_err <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            state  <= state_nxt;
            sync1  <= spi_done_send;
            done_s <= sync1;

            // Counter restarts on every state change, so LOAD and WAIT each get a full budget
            if (state_nxt != state) begin
                wd_cnt <= '0;
            end else if (state == LOAD || state == WAIT) begin
                wd_cnt <= wd_cnt + WDW'(1);
            end

            if (state == GRANT && any_req) begin
                grant_id    <= pick;
                spi_data_in <= req_data[int'(pick)*DATA_W +: DATA_W];
            end

            if (state == ACK || abort) ptr <= grant_id;
            if (abort) timeout_err <= 1'b1;
        end
    end

    assign spi_load_data = (state == LOAD);
    assign busy          = (state == GRANT) || (state == LOAD) || (state == WAIT);
    assign ack           = (state == ACK) ? (NUM_REQ'(1) << grant_id) : '0;
    assign state_dbg     = state;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed and randomised bench for spi_tx_arbiter with an inline transmitter model
// and a round-robin reference model driven from the requester vector.
module tb_spi_tx_arbiter;
    import spi_pkg::*;

    localparam int N  = 4;
    localparam int W  = 24;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [W-1:0]     d [N];
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     ack;
    logic [1:0]       grant_id;
    logic             busy;
    logic [W-1:0]     spi_data_in;
    logic             spi_load_data;
    logic             spi_done_send;
    logic             timeout_err;
    arb_state_e       state_dbg;

    int total = 0;
    int bad   = 0;
    int ptr_m = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = d[i];
    end

    spi_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .ack           (ack),
        .grant_id      (grant_id),
        .busy          (busy),
        .spi_data_in   (spi_data_in),
        .spi_load_data (spi_load_data),
        .spi_done_send (spi_done_send),
        .timeout_err   (timeout_err),
        .state_dbg     (state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int i = 1; i <= N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic xfer(input bit stuck, input bit drop_mid, input bit drop_on_ack,
                        input int exp_load_lat);
        int exp_id;
        int n;
        int lat;
        bit seen_ack;
        logic [W-1:0] exp_data;
        exp_id = model_pick(req, ptr_m);
        chk("model_has_req", 32'(exp_id >= 0), 32'd1);
        if (exp_id < 0) return;
        exp_q.push_back(d[exp_id]);
        n = 0;
        while (!spi_load_data && n < 40) begin step(); n++; end
        chk("load_seen", 32'(spi_load_data), 32'd1);
        exp_data = exp_q.pop_front();
        if (!spi_load_data) return;
        if (exp_load_lat >= 0) chk("load_latency", n, exp_load_lat);
        chk("grant_id", 32'(grant_id), exp_id);
        chk("spi_data_in", 32'(spi_data_in), 32'(exp_data));
        chk("busy_load", 32'(busy), 32'd1);
        d[exp_id] = W'($urandom());
        if (stuck) begin
            n = 1;
            seen_ack = (ack != '0);
            while (spi_load_data && n < 100) begin
                step();
                if (ack != '0) seen_ack = 1'b1;
                if (spi_load_data) n++;
            end
            chk("timeout_len", n, TO);
            chk("timeout_err_set", 32'(timeout_err), 32'd1);
            chk("busy_abort", 32'(busy), 32'd0);
            chk("no_ack_abort", 32'(seen_ack), 32'd0);
            ptr_m = exp_id;
            req[exp_id] = 1'b0;
            return;
        end
        repeat ($urandom_range(0, 4)) step();
        chk("load_hold", 32'(spi_load_data), 32'd1);
        spi_done_send = 1'b0;
        n = 0;
        while (spi_load_data && n < 20) begin step(); n++; end
        chk("load_drop_lat", n, 3);
        if (drop_mid) req[exp_id] = 1'b0;
        repeat ($urandom_range(1, 5)) step();
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_no_ack", 32'(ack), 32'd0);
        spi_done_send = 1'b1;
        lat = 0;
        while (ack == '0 && lat < 20) begin step(); lat++; end
        chk("ack_lat", lat, 3);
        chk("ack_vec", 32'(ack), 32'd1 << exp_id);
        chk("data_stable", 32'(spi_data_in), 32'(exp_data));
        ptr_m = exp_id;
        if (drop_on_ack) req[exp_id] = 1'b0;
        step();
        chk("ack_once", 32'(ack), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        req = '0;
        spi_done_send = 1'b1;
        for (int i = 0; i < N; i++) d[i] = W'($urandom());
        repeat (3) step();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(spi_data_in), 32'd0);
        chk("rst_load", 32'(spi_load_data), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        repeat (4) step();

        // single request
        d[1] = 24'hA5C3F0;
        req  = 4'b0010;
        xfer(0, 0, 1, 2);

        // full contention, requests held across acks
        req = 4'b1111;
        for (int k = 0; k < 5; k++) xfer(0, 0, 0, -1);
        req = '0;
        step();

        // random request mixes
        for (int k = 0; k < 8; k++) begin
            req = req | N'($urandom_range(1, 15));
            xfer(0, 0, 1, -1);
        end
        for (int k = 0; k < N && req != '0; k++) xfer(0, 0, 1, -1);
        step();

        // pointer wrap from last grant 3
        req = 4'b1000;
        xfer(0, 0, 1, -1);
        req = 4'b1001;
        xfer(0, 0, 1, -1);
        chk("wrap_first", 32'(grant_id), 32'd0);
        xfer(0, 0, 1, -1);
        chk("wrap_second", 32'(grant_id), 32'd3);

        // requester drops during WAIT
        req = 4'b0100;
        xfer(0, 1, 0, -1);
        repeat (8) step();
        chk("no_regrant_busy", 32'(busy), 32'd0);
        chk("no_regrant_load", 32'(spi_load_data), 32'd0);

        // transmitter never accepts
        req = 4'b0011;
        xfer(1, 0, 0, -1);
        xfer(0, 0, 1, -1);
        chk("timeout_sticky", 32'(timeout_err), 32'd1);
        step();

        // reset while waiting for transfer completion
        req = 4'b0100;
        n = 0;
        while (!spi_load_data && n < 40) begin step(); n++; end
        chk("rw_load_seen", 32'(spi_load_data), 32'd1);
        spi_done_send = 1'b0;
        n = 0;
        while (spi_load_data && n < 20) begin step(); n++; end
        chk("rw_in_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        chk("rw_ack", 32'(ack), 32'd0);
        chk("rw_grant_id", 32'(grant_id), 32'd0);
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_data", 32'(spi_data_in), 32'd0);
        chk("rw_load", 32'(spi_load_data), 32'd0);
        chk("rw_timeout", 32'(timeout_err), 32'd0);
        rst   = 1'b0;
        ptr_m = 0;
        repeat (6) step();
        chk("rw_hold_busy", 32'(busy), 32'd0);
        chk("rw_hold_load", 32'(spi_load_data), 32'd0);
        spi_done_send = 1'b1;
        xfer(0, 0, 1, -1);
        chk("rw_final_grant", 32'(grant_id), 32'd2);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
